// File: rtl/i_fetch_pkg.sv
// Shared fetch-stage definitions: reset PC default, NOP word, FSM encodings
// and the layout of one instruction-buffer entry.
package i_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with single-cycle flush. Pointers carry one extra wrap bit
// so full/empty fall out of a plain compare.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/i_fetch.sv
// Instruction fetch: owns the PC, keeps one imem read outstanding at most,
// buffers returned words with their PC and hands them to decode.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_FETCH | idle; issue a request once the buffer has room
// ST_WAIT  | request outstanding; on ack push word, chain next if room left
// ST_DROP  | redirected while outstanding; wait for ack and discard it
module i_fetch
  import i_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         req_q, req_d;

  logic         fifo_push;
  logic         fifo_flush;
  logic         fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t fifo_wdata;
  fetch_entry_t fifo_head;
  logic         pop;
  logic [CW:0]  count_after;

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = !fifo_empty;
  assign instruction = instr_valid ? fifo_head.word : NOP_WORD;
  assign instr_pc    = instr_valid ? fifo_head.pc   : 32'h0;

  assign pop         = instr_valid && instr_ready;
  assign count_after = {1'b0, fifo_count} + (CW+1)'(1) - {{CW{1'b0}}, pop};
  assign fifo_wdata  = '{word: imem_rdata, pc: addr_q};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        // A redirect this cycle makes pc_q stale, so hold off one cycle.
        if (!redirect_valid && (fifo_count < CW'(FIFO_DEPTH))) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            req_d   = 1'b0;
            state_d = ST_FETCH;
          end else begin
            fifo_push = 1'b1;
            pc_d      = pc_q + 32'd4;
            if (count_after < (CW+1)'(FIFO_DEPTH)) begin
              addr_d = pc_q + 32'd4;
            end else begin
              req_d   = 1'b0;
              state_d = ST_FETCH;
            end
          end
        end else if (redirect_valid) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = ST_FETCH;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_FETCH;
      end
    endcase

    if (redirect_valid) begin
      fifo_flush = 1'b1;
      pc_d       = word_align(redirect_pc);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= 32'h0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  fetch_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (instr_ready),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule
